// File: rtl/top_varint_deser.sv
// Varint deserializer: fetches up to MAX_BYTES wire bytes over the 8-lane DRAM
// read port, decodes a base-128 varint and applies protobuf type handling.
module top_varint_deser #(
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned MAX_BYTES      = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [63:0]     src_addr,
    input  logic [4:0]      field_type,
    output logic [7:0]      dram_en,
    output logic [7:0][63:0] dram_addr,
    output logic            dram_rdwr,
    input  logic            dram_valid,
    input  logic [7:0][7:0] dram_data,
    output logic            done,
    output logic            error,
    output logic [63:0]     value,
    output logic [3:0]      bytes_read
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned B1_LANES = MAX_BYTES - 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] DECODE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;
    localparam logic [2:0] HOLD   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic             burst_q, burst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d;
    logic [7:0][7:0]  data_q, data_d;
    logic [63:0]      addr_q, addr_d;
    logic [4:0]       type_q, type_d;
    logic [7:0]       dram_en_q, dram_en_d;
    logic [7:0][63:0] dram_addr_q, dram_addr_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [63:0]      value_q, value_d;
    logic [3:0]       bytes_q, bytes_d;

    logic [63:0]      acc_dec;
    logic             found_dec;
    logic [3:0]       nbytes_dec;

    // Protobuf type handling: zigzag for sint32/sint64, 32-bit truncation/extension.
    function automatic logic [63:0] post_proc(input logic [63:0] acc, input logic [4:0] ftype);
        logic [31:0] v32;
        logic [31:0] z32;
        v32 = acc[31:0];
        z32 = (v32 >> 1) ^ {32{v32[0]}};
        case (ftype)
            5'd17:                          post_proc = {{32{z32[31]}}, z32};
            5'd18:                          post_proc = (acc >> 1) ^ {64{acc[0]}};
            5'd5:                           post_proc = {{32{v32[31]}}, v32};
            5'd0, 5'd2, 5'd7, 5'd13, 5'd15: post_proc = {32'd0, v32};
            default:                        post_proc = acc;
        endcase
    endfunction

    // Accumulate 7-bit groups of the latched burst up to the first terminator byte.
    always_comb begin
        int unsigned nl;
        int unsigned base;
        int unsigned sh;
        acc_dec    = acc_q;
        found_dec  = 1'b0;
        nbytes_dec = '0;
        nl         = burst_q ? B1_LANES : 8;
        base       = burst_q ? 8 : 0;
        sh         = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found_dec && (i < nl)) begin
                sh      = 7 * (base + i);
                acc_dec = acc_dec | (64'(data_q[i][6:0]) << sh);
                if (!data_q[i][7]) begin
                    found_dec  = 1'b1;
                    nbytes_dec = 4'(base + i + 1);
                end
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        int unsigned nl_req;
        int unsigned base_req;
        state_d     = state_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        data_d      = data_q;
        addr_d      = addr_q;
        type_d      = type_q;
        dram_en_d   = '0;
        dram_addr_d = dram_addr_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        value_d     = value_q;
        bytes_d     = bytes_q;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_d   = '0;
                    burst_d = 1'b0;
                    addr_d  = src_addr;
                    type_d  = field_type;
                    state_d = REQ;
                end
                REQ: begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (dram_valid) begin
                        for (int unsigned i = 0; i < 8; i++) begin
                            data_d[i] = (i < (burst_q ? B1_LANES : 8)) ? dram_data[i] : 8'h00;
                        end
                        cnt_d   = '0;
                        state_d = DECODE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cnt_d   = '0;
                        error_d = 1'b1;
                        value_d = '0;
                        bytes_d = '0;
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DECODE: begin
                    acc_d = acc_dec;
                    if (found_dec) begin
                        value_d = post_proc(acc_dec, type_q);
                        bytes_d = nbytes_dec;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (!burst_q) begin
                        burst_d = 1'b1;
                        state_d = REQ;
                    end else begin
                        error_d = 1'b1;
                        value_d = '0;
                        bytes_d = '0;
                        state_d = ERR;
                    end
                end
                DONE:    state_d = HOLD;
                ERR:     state_d = HOLD;
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end

        // Issue the read strobes so they are visible during the REQ cycle.
        nl_req   = burst_d ? B1_LANES : 8;
        base_req = burst_d ? 8 : 0;
        if (state_d == REQ) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (i < nl_req) begin
                    dram_en_d[i]   = 1'b1;
                    dram_addr_d[i] = addr_d + 64'(base_req + i);
                end else begin
                    dram_addr_d[i] = '0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            burst_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            type_q      <= '0;
            dram_en_q   <= '0;
            dram_addr_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            value_q     <= '0;
            bytes_q     <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            type_q      <= type_d;
            dram_en_q   <= dram_en_d;
            dram_addr_q <= dram_addr_d;
            done_q      <= done_d;
            error_q     <= error_d;
            value_q     <= value_d;
            bytes_q     <= bytes_d;
        end
    end

    assign dram_en    = dram_en_q;
    assign dram_addr  = dram_addr_q;
    assign dram_rdwr  = 1'b1;
    assign done       = done_q;
    assign error      = error_q;
    assign value      = value_q;
    assign bytes_read = bytes_q;

endmodule

// File: tb/tb_top_varint_deser.sv
// Directed bench for top_varint_deser with a small DRAM responder model.
module tb_top_varint_deser;

    localparam int unsigned TO = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [63:0]      src_addr;
    logic [4:0]       field_type;
    logic [7:0]       dram_en;
    logic [7:0][63:0] dram_addr;
    logic             dram_rdwr;
    logic             dram_valid;
    logic [7:0][7:0]  dram_data;
    logic             done;
    logic             error;
    logic [63:0]      value;
    logic [3:0]       bytes_read;

    top_varint_deser #(.TIMEOUT_CYCLES(TO), .MAX_BYTES(10)) dut (
        .clk(clk), .reset(reset), .en(en), .src_addr(src_addr), .field_type(field_type),
        .dram_en(dram_en), .dram_addr(dram_addr), .dram_rdwr(dram_rdwr),
        .dram_valid(dram_valid), .dram_data(dram_data),
        .done(done), .error(error), .value(value), .bytes_read(bytes_read)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][7:0] b;
        logic [63:0]      src;
        logic [4:0]       ftype;
        int               lat;
        logic [63:0]      exp_val;
        logic [3:0]       exp_bytes;
        bit               exp_err;
        int               exp_req;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    // DRAM model state
    logic [15:0][7:0] mem;
    logic [63:0]      mem_base;
    int               lat_cfg = 0;
    bit               resp_on = 1'b1;
    int               pend = -1;
    logic [7:0][63:0] pend_addr;
    logic [7:0]       pend_en;

    function automatic logic [7:0] mem_rd(input logic [63:0] a);
        logic [63:0] off;
        off = a - mem_base;
        if (off < 64'd16) return mem[off[3:0]];
        return 8'h00;
    endfunction

    // Responds to each strobe with dram_valid lat_cfg+1 cycles later.
    always begin
        @(posedge clk);
        #1;
        dram_valid = 1'b0;
        if (pend == 0) begin
            dram_valid = 1'b1;
            for (int i = 0; i < 8; i++) dram_data[i] = pend_en[i] ? mem_rd(pend_addr[i]) : 8'h00;
            pend = -1;
        end else if (pend > 0) begin
            pend = pend - 1;
        end
        if (dram_en != 8'h00 && resp_on) begin
            pend_en   = dram_en;
            pend_addr = dram_addr;
            pend      = lat_cfg;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_decode(input vec_t v, input string tag);
        int cyc, ndone, nerr, nreq, fin;
        logic [7:0][63:0] ea;
        mem        = v.b;
        mem_base   = v.src;
        src_addr   = v.src;
        field_type = v.ftype;
        lat_cfg    = v.lat;
        resp_on    = 1'b1;
        en         = 1'b1;
        cyc = 0; ndone = 0; nerr = 0; nreq = 0; fin = -1;
        for (int k = 0; k < 80; k++) begin
            step();
            cyc++;
            if (dram_en != 8'h00) begin
                for (int i = 0; i < 8; i++)
                    ea[i] = (nreq == 0) ? v.src + 64'(i) : ((i < 2) ? v.src + 64'(8 + i) : 64'd0);
                chk({tag, " req_en"}, 64'(dram_en), (nreq == 0) ? 64'hFF : 64'h03);
                tests_run++;
                if (dram_addr !== ea) begin
                    tests_failed++;
                    $display("FAIL %s req_addr: got %h expected %h", tag, dram_addr, ea);
                end
                nreq++;
            end
            if (done)  ndone++;
            if (error) nerr++;
            if ((done || error) && fin < 0) fin = cyc;
            if (fin >= 0 && cyc > fin + 2) break;
        end
        if (fin < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: no done/error within budget", tag);
        end
        chk({tag, " value"}, value, v.exp_val);
        chk({tag, " bytes_read"}, 64'(bytes_read), 64'(v.exp_bytes));
        chk({tag, " done_cnt"}, 64'(ndone), v.exp_err ? 64'd0 : 64'd1);
        chk({tag, " err_cnt"}, 64'(nerr), v.exp_err ? 64'd1 : 64'd0);
        chk({tag, " req_cnt"}, 64'(nreq), 64'(v.exp_req));
        if (v.lat == 0 && v.exp_req == 1 && !v.exp_err)
            chk({tag, " latency"}, 64'(fin), 64'd4);
        en = 1'b0;
        step();
        step();
    endtask

    vec_t tbl[11];
    vec_t post;

    initial begin
        int errc, c;
        reset = 1'b1; en = 1'b0; src_addr = '0; field_type = '0;
        dram_valid = 1'b0; dram_data = '0; mem = '0; mem_base = '0;

        for (int k = 0; k < 11; k++) begin
            tbl[k].b = '0; tbl[k].lat = 0; tbl[k].exp_err = 1'b0; tbl[k].exp_req = 1;
        end
        tbl[0].src = 64'h1000; tbl[0].ftype = 5'd4;  tbl[0].b[0] = 8'h96; tbl[0].b[1] = 8'h01;
        tbl[0].exp_val = 64'd150; tbl[0].exp_bytes = 4'd2;
        tbl[1].src = 64'h2000; tbl[1].ftype = 5'd17; tbl[1].lat = 1; tbl[1].b[0] = 8'h03;
        tbl[1].exp_val = 64'hFFFF_FFFF_FFFF_FFFE; tbl[1].exp_bytes = 4'd1;
        tbl[2].src = 64'h2040; tbl[2].ftype = 5'd17; tbl[2].b[0] = 8'h01;
        tbl[2].exp_val = 64'hFFFF_FFFF_FFFF_FFFF; tbl[2].exp_bytes = 4'd1;
        tbl[3].src = 64'h3000; tbl[3].ftype = 5'd3;
        for (int i = 0; i < 9; i++) tbl[3].b[i] = 8'hFF;
        tbl[3].b[9] = 8'h01; tbl[3].exp_req = 2;
        tbl[3].exp_val = 64'hFFFF_FFFF_FFFF_FFFF; tbl[3].exp_bytes = 4'd10;
        tbl[4].src = 64'h4000; tbl[4].ftype = 5'd4; tbl[4].lat = 2;
        for (int i = 0; i < 10; i++) tbl[4].b[i] = 8'h80;
        tbl[4].exp_err = 1'b1; tbl[4].exp_req = 2; tbl[4].exp_val = 64'd0; tbl[4].exp_bytes = 4'd0;
        tbl[5].src = 64'h5000; tbl[5].ftype = 5'd5;
        for (int i = 0; i < 4; i++) tbl[5].b[i] = 8'hFF;
        tbl[5].b[4] = 8'h0F; tbl[5].exp_val = 64'hFFFF_FFFF_FFFF_FFFF; tbl[5].exp_bytes = 4'd5;
        tbl[6].src = 64'h5100; tbl[6].ftype = 5'd0;
        for (int i = 0; i < 4; i++) tbl[6].b[i] = 8'hFF;
        tbl[6].b[4] = 8'h1F; tbl[6].exp_val = 64'h0000_0000_FFFF_FFFF; tbl[6].exp_bytes = 4'd5;
        tbl[7].src = 64'h6000; tbl[7].ftype = 5'd18; tbl[7].b[0] = 8'h03;
        tbl[7].exp_val = 64'hFFFF_FFFF_FFFF_FFFE; tbl[7].exp_bytes = 4'd1;
        tbl[8].src = 64'h6100; tbl[8].ftype = 5'd18; tbl[8].lat = 3; tbl[8].b[0] = 8'h04;
        tbl[8].exp_val = 64'd2; tbl[8].exp_bytes = 4'd1;
        tbl[9].src = 64'h7000; tbl[9].ftype = 5'd4;
        for (int i = 0; i < 8; i++) tbl[9].b[i] = 8'h80;
        tbl[9].b[8] = 8'h01; tbl[9].exp_req = 2;
        tbl[9].exp_val = 64'h0100_0000_0000_0000; tbl[9].exp_bytes = 4'd9;
        tbl[10].src = 64'h7100; tbl[10].ftype = 5'd17; tbl[10].b[0] = 8'hFE;
        for (int i = 1; i < 4; i++) tbl[10].b[i] = 8'hFF;
        tbl[10].b[4] = 8'h0F; tbl[10].exp_val = 64'h0000_0000_7FFF_FFFF; tbl[10].exp_bytes = 4'd5;

        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst dram_en", 64'(dram_en), 64'd0);
        chk("rst dram_addr0", dram_addr[0], 64'd0);
        chk("rst dram_addr7", dram_addr[7], 64'd0);
        chk("rst dram_rdwr", 64'(dram_rdwr), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst error", 64'(error), 64'd0);
        chk("rst value", value, 64'd0);
        chk("rst bytes_read", 64'(bytes_read), 64'd0);

        for (int k = 0; k < 11; k++) run_decode(tbl[k], $sformatf("vec%0d", k));

        // Timeout: no response ever, error TO cycles after WAIT entry (cycle 2)
        resp_on = 1'b0; src_addr = 64'h9000; field_type = 5'd4;
        en = 1'b1; errc = -1; c = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            c++;
            if (done) chk("to done", 64'(done), 64'd0);
            if (error && errc < 0) errc = c;
        end
        chk("to err_cycle", 64'(errc), 64'(2 + TO));
        chk("to value", value, 64'd0);
        chk("to bytes_read", 64'(bytes_read), 64'd0);
        repeat (3) step();
        chk("hold no_req", 64'(dram_en), 64'd0);
        chk("hold no_err", 64'(error), 64'd0);
        en = 1'b0; step();
        mem = '0; mem[0] = 8'h05; mem_base = src_addr; resp_on = 1'b1; lat_cfg = 0;
        en = 1'b1; step();
        chk("restart req_en", 64'(dram_en), 64'hFF);
        c = 0;
        while (!done && c < 20) begin step(); c++; end
        chk("restart done", 64'(done), 64'd1);
        chk("restart value", value, 64'd5);
        en = 1'b0; step(); step();

        // Abort during WAIT, late response must be ignored
        mem = '0; mem[0] = 8'h7F; mem_base = 64'hA000; src_addr = 64'hA000;
        lat_cfg = 6; en = 1'b1;
        step(); step(); step();
        en = 1'b0;
        errc = 0; c = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (done) errc++;
            if (error) c++;
        end
        chk("abort done", 64'(errc), 64'd0);
        chk("abort error", 64'(c), 64'd0);
        chk("abort value_kept", value, 64'd5);
        chk("abort bytes_kept", 64'(bytes_read), 64'd1);
        post.b = '0; post.b[0] = 8'hFF; post.b[1] = 8'hFF; post.b[2] = 8'h03;
        post.src = 64'hB000; post.ftype = 5'd4; post.lat = 0;
        post.exp_val = 64'hFFFF; post.exp_bytes = 4'd3; post.exp_err = 1'b0; post.exp_req = 1;
        run_decode(post, "post_abort");

        // Reset in the middle of a decode
        resp_on = 1'b0; src_addr = 64'hC000; en = 1'b1;
        step(); step();
        reset = 1'b1; en = 1'b0;
        step();
        chk("midrst dram_en", 64'(dram_en), 64'd0);
        chk("midrst value", value, 64'd0);
        chk("midrst bytes_read", 64'(bytes_read), 64'd0);
        chk("midrst dram_addr0", dram_addr[0], 64'd0);
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/top_varint_deser.md
Name: top_varint_deser

Overview:
- Varint deserializer and the read-side counterpart of the varint serializer top.
- Given a source address and protobuf field type, fetches wire bytes from DRAM over the 8-lane byte interface and decodes a base-128 varint of up to 10 bytes.
- Applies zigzag decode (sint32/sint64) and 32-bit width handling, then reports the decoded 64-bit value and the number of bytes consumed.
- Sits in the parse datapath beside the fixed-width field readers.

Parameters:
- TIMEOUT_CYCLES, 32: max cycles waiting for dram_valid after a request before flagging error.
- MAX_BYTES, 10: max varint length; byte 10 with continuation bit set is malformed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  start/hold; must stay high for the whole decode; low aborts
- src_addr  in  64  address of first wire byte
- field_type  in  5  protobuf field type code
- dram_en  out  8  per-lane read strobe, one-cycle pulse
- dram_addr  out  8x64  per-lane byte address
- dram_rdwr  out  1  constant 1 (read)
- dram_valid  in  1  response valid for last request
- dram_data  in  8x8  response bytes; lane i answers dram_addr[i]
- done  out  1  one-cycle pulse, decode complete
- error  out  1  one-cycle pulse, timeout or malformed
- value  out  64  decoded value, held until next start
- bytes_read  out  4  bytes consumed (1..10), held until next start

Behaviour:
- Reset values: dram_en=0, dram_addr=0, dram_rdwr=1, done=0, error=0, value=0, bytes_read=0. State=IDLE; accumulator, burst index and timeout counter are 0.
- Wire order: byte k is at src_addr+k (ascending addresses).
- States: IDLE, REQ, WAIT, DECODE, DONE, ERR, HOLD.
- IDLE: when en=1, clear accumulator, set burst=0, go to REQ.
- REQ (1 cycle):
  - burst 0: dram_en=8'hFF, dram_addr[i]=src_addr+i.
  - burst 1: dram_en=8'h03, dram_addr[i]=src_addr+8+i for i<2; other lanes' addr=0.
  - Go to WAIT.
- WAIT:
  - dram_en=0; counter increments each cycle.
  - dram_valid=1: latch the enabled lanes, clear counter, go to DECODE.
  - Counter reaches TIMEOUT_CYCLES-1 with no valid: go to ERR.
  - dram_valid outside WAIT is ignored.
- DECODE (1 cycle), over latched lanes in lane order:
  - acc |= byte[6:0] << 7*(8*burst+i), stopping at the first byte with bit7=0.
  - Bits beyond bit 63 are dropped, so byte 10 contributes only bit0.
  - Terminator found: bytes_read=8*burst+i+1, go to DONE.
  - None in burst 0: burst=1, go to REQ.
  - None in burst 1 (byte 10 has bit7=1): go to ERR.
- Value post-processing, registered into value on entry to DONE:
  - types 17 (sint32): v32=acc[31:0]; (v32>>1)^-(v32&1), sign-extended to 64.
  - type 18 (sint64): (acc>>1)^-(acc&1).
  - type 5 (int32): acc[31:0] sign-extended.
  - types 0,2,7,13,15: acc[31:0] zero-extended.
  - all other types: acc unchanged.
- DONE: done=1 for exactly one cycle, then HOLD.
- ERR: error=1 for exactly one cycle; value=0, bytes_read=0; then HOLD.
- HOLD: outputs held; returns to IDLE only when en=0. A new decode requires en low for at least one cycle.
- en=0 in any state: next state IDLE, dram_en=0, counter cleared, done/error not asserted. value and bytes_read keep their last values; no pending response is consumed.
- reset mid-operation: immediate return to reset values at the clock edge.
- Latency, 1-burst varint with zero-wait DRAM: en high in IDLE (cycle 0) → REQ (1) → WAIT, valid seen (2) → DECODE (3) → done=1 (4).
- done and error are never high in the same cycle.

Test Plan:
- Bytes 96 01 at src_addr=0x1000, type 4, valid 1 cycle after request → dram_addr[0..7]=0x1000..0x1007, value=150, bytes_read=2, done pulses once, single burst.
- Byte 03, type 17 (sint32) → value=0xFFFF_FFFF_FFFF_FFFE; byte 01, type 17 → 0xFFFF_FFFF_FFFF_FFFF; bytes_read=1.
- Nine FF then 01, type 3 (int64) → second request has dram_en=8'h03 at src_addr+8/+9, value=0xFFFF_FFFF_FFFF_FFFF, bytes_read=10.
- Ten bytes of 80, type 4 → error pulse after second DECODE, done=0, value=0, bytes_read=0.
- dram_valid never asserted → error exactly TIMEOUT_CYCLES cycles after WAIT entry; en held → stays in HOLD; en low one cycle then high → fresh REQ.
- en dropped during WAIT, then a late dram_valid → no done/error, late response ignored; next decode with FF FF 03, type 4 → value=0xFFFF, bytes_read=3.
